// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM burst arbiter: default geometry and the
// FSM state encoding used by rom_arbiter.
package rom_arb_pkg;

  // Default ROM geometry. Each address reads a pair of words: mem[a] and mem[a+NUMADDR].
  localparam int WORDSIZE_DEF = 16;
  localparam int ADDRSIZE_DEF = 5;
  localparam int NUMADDR_DEF  = 2 ** ADDRSIZE_DEF;

  // FSM state encoding.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_BURST = 2'd1;
  localparam arb_state_t ST_DRAIN = 2'd2;

  // One-hot grant vector for a requester id.
  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Bus bundle between the ROM arbiter and its environment: the two burst
// requesters, the ROM port and the response stream.
// The slave modport is the arbiter's view. The master modport is the
// surrounding system's view (requesters plus ROM).
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEF,
  parameter int ADDRSIZE = ADDRSIZE_DEF
) ();

  // requester side
  logic [1:0]          req;
  logic [ADDRSIZE-1:0] req_addr0;
  logic [ADDRSIZE-1:0] req_addr1;
  logic [ADDRSIZE-1:0] req_len0;
  logic [ADDRSIZE-1:0] req_len1;
  logic [1:0]          gnt;

  // ROM side
  logic                rom_cs;
  logic [ADDRSIZE-1:0] rom_addr;
  logic [WORDSIZE-1:0] rom_data1;
  logic [WORDSIZE-1:0] rom_data2;

  // response stream
  logic                rsp_valid;
  logic                rsp_id;
  logic [WORDSIZE-1:0] rsp_data1;
  logic [WORDSIZE-1:0] rsp_data2;
  logic                rsp_last;
  logic                busy;

  modport slave (
    input  req, req_addr0, req_addr1, req_len0, req_len1,
    input  rom_data1, rom_data2,
    output gnt, rom_cs, rom_addr,
    output rsp_valid, rsp_id, rsp_data1, rsp_data2, rsp_last, busy
  );

  modport master (
    output req, req_addr0, req_addr1, req_len0, req_len1,
    output rom_data1, rom_data2,
    input  gnt, rom_cs, rom_addr,
    input  rsp_valid, rsp_id, rsp_data1, rsp_data2, rsp_last, busy
  );

endinterface

// File: rtl/rom_arb_rr.sv
// Two-way round-robin picker. When both requesters are asking, the one that
// was not served most recently wins. A lone requester always wins.
// The output is one-hot, or all zero when nobody is requesting.
module rom_arb_rr (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] win
);

  // Resolve the request vector into a one-hot winner.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_served ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Burst arbiter in front of a dual-word ROM with registered outputs.
// Two requesters ask for bursts of consecutive addresses. The arbiter grants
// one of them, walks the ROM address for the burst length, and forwards the
// ROM words one cycle later, tagged with the owning requester.
//
// Build option: define ROM_ARB_FIXED_PRIO_EN to give requester 0 absolute
// priority. Without it, simultaneous requests are served round-robin.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ROM deselected; req sampled, winner's addr/len latched
// ST_BURST | one ROM address issued per cycle until the count runs out
// ST_DRAIN | ROM kept selected while the final registered word is consumed
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEF,
  parameter int ADDRSIZE = ADDRSIZE_DEF
) (
  input logic          clk,
  input logic          rst_n,
  rom_arbiter_if.slave bus
);

  localparam int NUMADDR = 2 ** ADDRSIZE;

  // The remaining-count is one bit wider than an address, so a full
  // NUMADDR-word burst (encoded as len 0) fits in it.
  localparam logic [ADDRSIZE:0]   CNT_FULL  = (ADDRSIZE + 1)'(NUMADDR);
  localparam logic [ADDRSIZE:0]   CNT_ONE   = (ADDRSIZE + 1)'(1);
  localparam logic [ADDRSIZE-1:0] ADDR_ONE  = ADDRSIZE'(1);
  localparam logic [WORDSIZE-1:0] ZERO_WORD = '0;

  arb_state_t          state;
  logic                cur_id;
  logic [ADDRSIZE-1:0] addr;
  logic [ADDRSIZE:0]   remaining;
  logic [1:0]          gnt_q;

  logic                rsp_valid_q;
  logic                rsp_last_q;
  logic                rsp_id_q;

  logic [1:0]          win;
  logic                win_id;
  logic [ADDRSIZE-1:0] win_addr;
  logic [ADDRSIZE-1:0] win_len;
  logic                accept;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is asking.
  always_comb win = bus.req[0] ? 2'b01 : (bus.req[1] ? 2'b10 : 2'b00);
`else
  logic last_served;

  rom_arb_rr u_rr (
    .req         (bus.req),
    .last_served (last_served),
    .win         (win)
  );

  // Remember who was granted last. The reset value of 1 hands the first
  // contested grant to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= 1'b1;
    end else if (accept) begin
      last_served <= win_id;
    end
  end
`endif

  // Requests are only looked at in IDLE. Changes during a burst are ignored.
  assign accept   = (state == ST_IDLE) && (win != 2'b00);
  assign win_id   = win[1];
  assign win_addr = win_id ? bus.req_addr1 : bus.req_addr0;
  assign win_len  = win_id ? bus.req_len1  : bus.req_len0;

  // Burst sequencing: latch the winner, walk the address, then one drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_id    <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      gnt_q     <= 2'b00;
    end else begin
      gnt_q <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_BURST;
            cur_id    <= win_id;
            addr      <= win_addr;
            remaining <= (win_len == '0) ? CNT_FULL : {1'b0, win_len};
            gnt_q     <= id_to_onehot(win_id);
          end
        end
        ST_BURST: begin
          // The address wraps naturally at NUMADDR.
          addr      <= addr + ADDR_ONE;
          remaining <= remaining - CNT_ONE;
          if (remaining == CNT_ONE) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Responses trail the ROM issue by one cycle, matching the ROM's output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      rsp_valid_q <= (state == ST_BURST);
      rsp_last_q  <= (state == ST_BURST) && (remaining == CNT_ONE);
      if (state == ST_BURST) begin
        rsp_id_q <= cur_id;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.rom_cs    = (state != ST_IDLE);
  assign bus.rom_addr  = (state == ST_IDLE) ? '0 : addr;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_id    = rsp_id_q;
  // The ROM bus tri-states when deselected, so data is masked outside valid words.
  assign bus.rsp_data1 = rsp_valid_q ? bus.rom_data1 : ZERO_WORD;
  assign bus.rsp_data2 = rsp_valid_q ? bus.rom_data2 : ZERO_WORD;

endmodule
